// File: rtl/uart_rx_to_parallel_if.sv
// Parallel-side bus of the UART receiver.
//   data_out    : received byte (receiver -> consumer)
//   data_valid  : data_out holds an unacknowledged byte
//   data_ack    : consumer acknowledges data_out (consumer -> receiver)
//   framing_err : one-cycle pulse, stop bit sampled low
//   overrun     : sticky, a byte completed while the previous one was pending
//   busy        : receiver is not idle
// master = receiver side, slave = consumer side.
interface uart_rx_to_parallel_if;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ack;
   logic       framing_err;
   logic       overrun;
   logic       busy;

   modport master (
      output data_out, data_valid, framing_err, overrun, busy,
      input  data_ack
   );

   modport slave (
      input  data_out, data_valid, framing_err, overrun, busy,
      output data_ack
   );
endinterface

// File: rtl/uart_rx_to_parallel.sv
// UART 8N1 receiver with a valid/ack parallel output.
//   clk   : system clock, posedge
//   reset : synchronous, active-high
//   rx    : asynchronous serial line, idles high
//   bus   : parallel handshake bus (master side), see uart_rx_to_parallel_if
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | line idle, waiting for rx_s low
// S_START   | half-bit wait, then confirm start bit is still low
// S_DATA    | sampling 8 data bits at mid-bit, LSB first
// S_STOP    | one bit wait, then check stop bit and deliver the byte
// S_WAIT_HI | stop bit was low; hold off until the line returns high
module uart_rx_to_parallel #(
   parameter int CLKS_PER_BIT = 256,
   parameter int CNT_W        = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   uart_rx_to_parallel_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_WAIT_HI = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   state_t            state_q, state_d;
   logic              sync1_q;
   logic              rx_s_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              data_valid_q, data_valid_d;
   logic              framing_err_q, framing_err_d;
   logic              overrun_q, overrun_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sync1_q       <= 1'b1;
         rx_s_q        <= 1'b1;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= rx;
         rx_s_q        <= sync1_q;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         framing_err_q <= framing_err_d;
         overrun_q     <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      data_out_d    = data_out_q;
      // an ack on a pending byte clears it; a completing byte below overrides
      data_valid_d  = data_valid_q & ~bus.data_ack;
      framing_err_d = 1'b0;
      overrun_d     = overrun_q;

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = HALF_LOAD;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  cnt_d     = FULL_LOAD;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = FULL_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d   = S_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s_q) begin
                  state_d      = S_IDLE;
                  data_out_d   = shift_q;
                  data_valid_d = 1'b1;
                  if (data_valid_q && !bus.data_ack) overrun_d = 1'b1;
               end else begin
                  state_d       = S_WAIT_HI;
                  framing_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT_HI: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.data_out    = data_out_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.framing_err = framing_err_q;
   assign bus.overrun     = overrun_q;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_to_parallel.sv
module tb_uart_rx_to_parallel;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int fe_cnt = 0;

   uart_rx_to_parallel_if bus ();

   uart_rx_to_parallel #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.framing_err === 1'b1) fe_cnt++;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       ack;
      logic [7:0] exp_out;
      logic       exp_valid;
      logic       exp_ovr;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // caller is at a negedge; returns at the negedge ending the stop bit
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic pulse_ack();
      bus.data_ack = 1'b1;
      @(negedge clk);
      bus.data_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      bus.data_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   logic [7:0] m_out;
   logic       m_valid, m_ovr;
   int         m_fe, fe_base;

   initial begin
      bus.data_ack = 1'b0;

      // expected values worked out by hand from the receive rules
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
      vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0};
      vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 0};
      vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 0};

      do_reset();
      check("rst_data_out", bus.data_out, 0);
      check("rst_valid", bus.data_valid, 0);
      check("rst_ferr", bus.framing_err, 0);
      check("rst_ovr", bus.overrun, 0);
      check("rst_busy", bus.busy, 0);

      // table vectors
      for (int v = 0; v < 6; v++) begin
         fe_base = fe_cnt;
         send_frame(vecs[v].data, vecs[v].stop);
         repeat (4) @(negedge clk);
         check($sformatf("vec%0d_out", v), bus.data_out, vecs[v].exp_out);
         check($sformatf("vec%0d_valid", v), bus.data_valid, vecs[v].exp_valid);
         check($sformatf("vec%0d_ovr", v), bus.overrun, vecs[v].exp_ovr);
         check($sformatf("vec%0d_fe", v), fe_cnt - fe_base, vecs[v].exp_fe);
         check($sformatf("vec%0d_busy", v), bus.busy, 0);
         if (vecs[v].ack) begin
            pulse_ack();
            check($sformatf("vec%0d_ack_valid", v), bus.data_valid, 0);
            check($sformatf("vec%0d_ack_ovr", v), bus.overrun, vecs[v].exp_ovr);
         end
      end

      // exact latency: valid rises on the 155th posedge after the start bit is driven
      do_reset();
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (154) @(negedge clk);
            check("lat_before", bus.data_valid, 0);
            @(negedge clk);
            check("lat_valid", bus.data_valid, 1);
            check("lat_out", bus.data_out, 8'hA5);
         end
      join
      repeat (4) @(negedge clk);

      // glitch: 4 low cycles, START must abort silently
      do_reset();
      fe_base = fe_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      check("glitch_busy_hi", bus.busy, 1);
      repeat (20) @(negedge clk);
      check("glitch_busy_lo", bus.busy, 0);
      check("glitch_valid", bus.data_valid, 0);
      check("glitch_fe", fe_cnt - fe_base, 0);

      // framing error with line held low afterwards
      fe_base = fe_cnt;
      send_frame(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (40) @(negedge clk);
      check("wait_hi_busy", bus.busy, 1);
      check("wait_hi_fe", fe_cnt - fe_base, 1);
      check("wait_hi_valid", bus.data_valid, 0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check("wait_hi_release", bus.busy, 0);
      check("wait_hi_out", bus.data_out, 0);

      // ack collides with completion of 0x55 while 0x11 is pending
      send_frame(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (154) @(negedge clk);
            check("coll_pre_out", bus.data_out, 8'h11);
            bus.data_ack = 1'b1;
            @(negedge clk);
            bus.data_ack = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("coll_out", bus.data_out, 8'h55);
      check("coll_valid", bus.data_valid, 1);
      check("coll_ovr", bus.overrun, 0);

      // reset after start + 4 data bits, then a clean frame
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (CPB) @(negedge clk);
      end
      reset = 1'b1;
      rx = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_out", bus.data_out, 0);
      check("midrst_valid", bus.data_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_ovr", bus.overrun, 0);
      repeat (3) @(negedge clk);
      send_frame(8'hF0, 1'b1);
      repeat (4) @(negedge clk);
      check("midrst_f0_out", bus.data_out, 8'hF0);
      check("midrst_f0_valid", bus.data_valid, 1);

      // randomized frames against a frame-level reference model
      do_reset();
      m_out = 8'h00;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_fe = 0;
      fe_base = fe_cnt;
      for (int f = 0; f < 30; f++) begin
         logic [7:0] b;
         logic sb;
         b = 8'($urandom);
         sb = ($urandom_range(0, 9) != 0);
         send_frame(b, sb);
         if (sb) begin
            if (m_valid) m_ovr = 1'b1;
            m_out = b;
            m_valid = 1'b1;
         end else begin
            m_fe++;
         end
         repeat ($urandom_range(2, 20)) @(negedge clk);
         check($sformatf("rnd%0d_out", f), bus.data_out, m_out);
         check($sformatf("rnd%0d_valid", f), bus.data_valid, m_valid);
         check($sformatf("rnd%0d_ovr", f), bus.overrun, m_ovr);
         check($sformatf("rnd%0d_fe", f), fe_cnt - fe_base, m_fe);
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            m_valid = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
